// File: rtl/seven_seg_mux_n.sv
// Multiplexed N-digit seven-segment controller.
// A free-running prescaler sets the slot length. A digit index scans the digits once
// per frame. Digit data is double-buffered and only changes at a frame boundary, so
// the display never shows half of an old value and half of a new one. Blanking,
// leading-zero suppression and PWM brightness are applied live to each slot.

// Per-digit lane: hex decode plus the conditions that keep this digit dark.
module seven_seg_mux_n_lane (
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  input  logic       supp_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       show_o
);

  // Active-high segment patterns, bit0=a .. bit6=g.
  always_comb begin
    seg_o = 7'h00;
    case (nib_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end

  // A suppressed or blanked digit also takes its decimal point dark.
  assign show_o = ~blank_i & ~supp_i;
  assign dp_o   = dp_i;

endmodule

module seven_seg_mux_n #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 17,
  parameter int BRIGHT_W    = 3,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_mask_i,
  input  logic                    lz_suppress_i,
  input  logic [BRIGHT_W-1:0]     brightness_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    frame_done_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL = ACTIVE_LOW;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] nib;
    logic [NUM_DIGITS-1:0]      dp;
  } frame_t;

  logic [REFRESH_DIV-1:0] cnt_q;
  logic [IDX_W-1:0]       idx_q;
  frame_t                 act_q, pend_q;
  logic                   pend_vld_q;

  logic tick, last_dig, boundary, commit;

  assign tick     = &cnt_q;
  assign last_dig = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign boundary = tick & last_dig;
  assign commit   = boundary & pend_vld_q;

  // Prescaler wraps naturally; each wrap advances the scanned digit.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_q + REFRESH_DIV'(1);
      if (tick) idx_q <= last_dig ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Double buffer. The commit reads the old pending value, so a load landing on
  // the boundary cycle is kept for the following frame.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (commit) act_q <= pend_q;
      if (load_i) begin
        pend_q.nib <= data_i;
        pend_q.dp  <= dp_i;
        pend_vld_q <= 1'b1;
      end else if (commit) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  // Leading-zero run from the leftmost digit down. Digit 0 is never suppressed.
  logic [NUM_DIGITS-1:0] supp;
  logic                  zrun;
  always_comb begin
    supp = '0;
    zrun = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zrun    = zrun & (act_q.nib[i] == 4'h0);
      supp[i] = lz_suppress_i & zrun;
    end
  end

  logic [NUM_DIGITS-1:0][6:0] lane_seg;
  logic [NUM_DIGITS-1:0]      lane_dp;
  logic [NUM_DIGITS-1:0]      lane_show;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    seven_seg_mux_n_lane u_lane (
      .nib_i   (act_q.nib[g]),
      .dp_i    (act_q.dp[g]),
      .blank_i (blank_mask_i[g]),
      .supp_i  (supp[g]),
      .seg_o   (lane_seg[g]),
      .dp_o    (lane_dp[g]),
      .show_o  (lane_show[g])
    );
  end

  // PWM: the top prescaler bits are compared against the brightness code, so an
  // all-ones code lights the whole slot.
  logic duty_on, lit;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  assign duty_on = (cnt_q[REFRESH_DIV-1 -: BRIGHT_W] <= brightness_i);
  assign lit     = lane_show[idx_q] & duty_on;
  assign an_d    = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
  assign seg_d   = lit ? lane_seg[idx_q] : 7'h00;
  assign dp_d    = lit & lane_dp[idx_q];

  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q, fd_q;

  // Output register. Polarity is applied here only, so an unlit slot drives every pin inactive.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      an_q  <= {NUM_DIGITS{POL}};
      seg_q <= {7{POL}};
      dp_q  <= POL;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d ^ {NUM_DIGITS{POL}};
      seg_q <= seg_d ^ {7{POL}};
      dp_q  <= dp_d ^ POL;
      fd_q  <= commit;
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Bench for seven_seg_mux_n. The reference model works from absolute cycle time
// since reset: slot = t / 2**REFRESH_DIV, digit = slot mod N, and a frame ends
// every N slots. Expected pin states are queued by the driver and checked by a
// separate monitor.
module tb_seven_seg_mux_n;
  localparam int N     = 4;
  localparam int RD    = 2;
  localparam int BW    = 1;
  localparam int SLOT  = 1 << RD;
  localparam int FRAME = N * SLOT;

  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz = 1'b0;
  logic [4*N-1:0] data = '0;
  logic [N-1:0]   dpin = '0, blank = '0;
  logic [BW-1:0]  br = '1;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic           dp, fd;

  seven_seg_mux_n #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BRIGHT_W(BW), .ACTIVE_LOW(1'b1)) dut (
    .clk_i(clk), .reset_i(rst_n), .load_i(load), .data_i(data), .dp_i(dpin),
    .blank_mask_i(blank), .lz_suppress_i(lz), .brightness_i(br),
    .an_o(an), .seg_o(seg), .dp_o(dp), .frame_done_o(fd));

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [N-1:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int fd_exp = 0, fd_seen = 0;

  // Model state
  int m_t = 0;
  logic [4*N-1:0] m_act = '0, m_pend = '0;
  logic [N-1:0]   m_actdp = '0, m_penddp = '0;
  bit             m_pv = 0;

  // Live settings the driver applies at the next step
  logic [4*N-1:0] cur_d = '0;
  logic [N-1:0]   cur_dp = '0, cur_bl = '0;
  logic           cur_lz = 1'b0;
  logic [BW-1:0]  cur_br = '1;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'b0111111; 4'h1: r = 7'b0000110; 4'h2: r = 7'b1011011; 4'h3: r = 7'b1001111;
      4'h4: r = 7'b1100110; 4'h5: r = 7'b1101101; 4'h6: r = 7'b1111101; 4'h7: r = 7'b0000111;
      4'h8: r = 7'b1111111; 4'h9: r = 7'b1101111; 4'hA: r = 7'b1110111; 4'hB: r = 7'b1111100;
      4'hC: r = 7'b0111001; 4'hD: r = 7'b1011110; 4'hE: r = 7'b1111001; default: r = 7'b1110001;
    endcase
    return r;
  endfunction

  // Pin state registered at the edge that ends model cycle m_t.
  function automatic exp_t model_out();
    exp_t e;
    int idx, phase;
    bit supp, lit;
    idx   = (m_t / SLOT) % N;
    phase = m_t % SLOT;
    supp  = 0;
    if (cur_lz && idx != 0) begin
      supp = 1;
      for (int j = idx; j < N; j++) if (m_act[4*j +: 4] != 4'h0) supp = 0;
    end
    lit   = !cur_bl[idx] && !supp && ((phase >> (RD - BW)) <= int'(cur_br));
    e.t   = m_t;
    e.an  = lit ? ~(N'(1) << idx) : '1;
    e.seg = lit ? ~hex7(m_act[4*idx +: 4]) : 7'h7F;
    e.dp  = lit ? ~m_actdp[idx] : 1'b1;
    e.fd  = (((m_t + 1) % FRAME) == 0) && m_pv;
    return e;
  endfunction

  // Called at a falling edge: drive inputs, queue expectation, advance the model.
  task automatic step(input bit ld);
    load = ld; data = cur_d; dpin = cur_dp; blank = cur_bl; lz = cur_lz; br = cur_br;
    q.push_back(model_out());
    if ((((m_t + 1) % FRAME) == 0) && m_pv) begin
      m_act = m_pend; m_actdp = m_penddp; m_pv = 0; fd_exp++;
    end
    if (ld) begin m_pend = cur_d; m_penddp = cur_dp; m_pv = 1; end
    m_t++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  task automatic goto_phase(input int r);
    int guard = 0;
    while ((m_t % FRAME) != r && guard < FRAME) begin step(1'b0); guard++; end
  endtask

  task automatic chk_idle(input string name);
    checks++;
    if (an !== '1 || seg !== 7'h7F || dp !== 1'b1 || fd !== 1'b0) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, want an=1111 seg=1111111 dp=1 fd=0",
               name, an, seg, dp, fd);
    end
  endtask

  // Monitor: one comparison per clock while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (fd === 1'b1) fd_seen++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp || fd !== e.fd) begin
          errors++;
          $display("FAIL pins@t%0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                   e.t, an, seg, dp, fd, e.an, e.seg, e.dp, e.fd);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    rst_n = 1'b1;

    // Frame boundary commit: 12AF appears from the second frame onward.
    cur_d = 16'h12AF; cur_dp = 4'b0101;
    step(1'b1);
    run(2 * FRAME);

    // Leading-zero suppression
    cur_lz = 1'b1; cur_d = 16'h0050; cur_dp = 4'b1111;
    step(1'b1);
    run(2 * FRAME);
    cur_d = 16'h0000;
    step(1'b1);
    run(2 * FRAME);
    cur_lz = 1'b0;

    // Load on the boundary cycle while another value is still pending
    goto_phase(5);
    cur_d = 16'h1111; cur_dp = 4'b0000;
    step(1'b1);
    goto_phase(FRAME - 1);
    cur_d = 16'h2222;
    step(1'b1);
    run(3 * FRAME);

    // Brightness and blanking
    cur_br = '0;
    run(2 * FRAME);
    cur_br = '1; cur_bl = 4'b0100;
    run(2 * FRAME);
    cur_bl = '0;

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if (k % 8 == 0) begin
        cur_bl = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        cur_lz = 1'($urandom);
        cur_br = BW'($urandom);
      end
      cur_d  = ($urandom_range(0, 2) == 0) ? (4*N)'($urandom_range(0, 255)) : (4*N)'($urandom);
      cur_dp = N'($urandom);
      step($urandom_range(0, 7) == 0);
    end

    // Reset in the middle of digit 2's slot
    begin
      int guard = 0;
      while (((m_t / SLOT) % N) != 2 && guard < FRAME) begin step(1'b0); guard++; end
    end
    cur_d = 16'h8888; cur_dp = '1;
    step(1'b1);
    run(1);
    rst_n = 1'b0;
    #1 chk_idle("async_reset");
    @(posedge clk); #1 chk_idle("reset_next_cycle");
    @(negedge clk);
    m_t = 0; m_act = '0; m_pend = '0; m_actdp = '0; m_penddp = '0; m_pv = 0;
    rst_n = 1'b1;
    run(FRAME);
    cur_d = 16'hC0DE; cur_dp = 4'b1000;
    step(1'b1);
    run(2 * FRAME);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left, want 0", q.size());
    end
    checks++;
    if (fd_seen != fd_exp) begin
      errors++;
      $display("FAIL frame_done_count: got %0d, want %0d", fd_seen, fd_exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
